// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority arbiter.
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  // Widest requester vector the helpers below handle.
  localparam int MAXN = 16;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index to one-hot. Callers slice the low N bits.
  function automatic logic [MAXN-1:0] idx2oh(input logic [3:0] idx);
    return MAXN'(1) << idx;
  endfunction

  // One-hot to index. Returns 0 for an all-zero vector.
  function automatic logic [3:0] oh2idx(input logic [MAXN-1:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < MAXN; i++) if (oh[i]) r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection. Round-robin uses a double-width copy of the
// candidates shifted so the bit after rr_ptr lands at position 0; the first
// set bit then gives the offset from the pointer. Fixed mode is plain
// lowest-index priority.
module arb_pick import arb_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] rr_ptr,
  input  logic          mode,
  output logic          win_valid,
  output logic [IW-1:0] win_idx
);

  // One extra bit so start (up to N) and start+offset (up to 2N-1) fit.
  localparam int SW = IW + 1;

  logic [N-1:0]   cand;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   shf;
  logic [SW-1:0]  start, pos, sum;
  logic [IW-1:0]  lo_idx;

  // Masked double-width priority encode plus a plain lowest-index encode.
  always_comb begin
    cand   = req & mask;
    dbl    = {cand, cand};
    start  = SW'(rr_ptr) + SW'(1);
    shf    = N'(dbl >> start);
    pos    = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (shf[i])  pos    = SW'(i);
      if (cand[i]) lo_idx = IW'(i);
    end
    sum = start + pos;
    if (sum >= SW'(N)) sum = sum - SW'(N);
    win_valid = |cand;
    win_idx   = mode ? lo_idx : sum[IW-1:0];
  end

endmodule

// File: rtl/arbiter_rr_moore.sv
// N-requester arbiter with registered one-hot grant. Round-robin or fixed
// priority, plus a hold limit that forces the owner to yield to other
// pending requesters after MAX_HOLD consecutive cycles.
module arbiter_rr_moore import arb_pkg::*; #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IW       = clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id,
  output logic          hold_timeout
);

  localparam int            HW        = clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e      state, state_d;
  logic [IW-1:0]   rr_ptr, rr_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic            owner_req, at_limit;
  logic [N-1:0]    mask;
  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic            new_grant, pulse_d;
  logic [N-1:0]    grant_d;
  logic            valid_d;
  logic [IW-1:0]   id_d;
  logic [MAXN-1:0] oh_full;

  // Owner still requesting, and whether it has used up its hold budget.
  // At the limit the owner is masked out so only others can win.
  always_comb begin
    owner_req = |(req & grant);
    at_limit  = (hold_cnt == HOLD_LAST);
    mask      = (state == BUSY && owner_req && at_limit) ? ~grant : '1;
  end

  arb_pick #(.N(N), .IW(IW)) u_pick (
    .req       (req),
    .mask      (mask),
    .rr_ptr    (rr_ptr),
    .mode      (mode),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  // State, pointer, hold counter and output flops; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= IW'(N - 1);
      hold_cnt     <= '0;
      grant        <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_d;
      hold_cnt     <= hold_d;
      grant        <= grant_d;
      grant_valid  <= valid_d;
      grant_id     <= id_d;
      hold_timeout <= pulse_d;
    end
  end

  // Next-state: decide between keep, re-arbitrate, forced rotation or idle.
  always_comb begin
    state_d   = state;
    rr_d      = rr_ptr;
    hold_d    = hold_cnt;
    new_grant = 1'b0;
    pulse_d   = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          new_grant = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          if (win_valid) new_grant = 1'b1;
          else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (!at_limit) begin
          hold_d = hold_cnt + HW'(1);
        end else if (win_valid) begin
          new_grant = 1'b1;
          pulse_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (new_grant) begin
      rr_d   = win_idx;
      hold_d = '0;
    end
  end

  // Output next-values: load the winner, clear on idle, otherwise hold.
  always_comb begin
    oh_full = idx2oh(4'(win_idx));
    grant_d = grant;
    valid_d = grant_valid;
    id_d    = grant_id;
    if (new_grant) begin
      grant_d = oh_full[N-1:0];
      valid_d = 1'b1;
      id_d    = win_idx;
    end else if (state_d == IDLE) begin
      grant_d = '0;
      valid_d = 1'b0;
      id_d    = '0;
    end
  end

endmodule

// File: tb/tb_arbiter_rr_moore.sv
// Bench for arbiter_rr_moore with N=4, MAX_HOLD=4: a vector table drives
// one cycle per entry, expectations go through a scoreboard queue, and a few
// hand sequences cover reset behaviour.
module tb_arbiter_rr_moore;

  localparam int N = 4, MAX_HOLD = 4, IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          mode;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          hold_timeout;

  arbiter_rr_moore #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .mode         (mode),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    bit           mode;
    logic [N-1:0] eg;
    bit           eto;
  } vec_t;

  typedef struct {
    logic [N-1:0] g;
    bit           to;
    string        tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] oh_id(input logic [N-1:0] g);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic cmp_out(input exp_t e);
    chk({e.tag, ".grant"},   32'(grant),        32'(e.g));
    chk({e.tag, ".valid"},   32'(grant_valid),  32'(|e.g));
    chk({e.tag, ".id"},      32'(grant_id),     oh_id(e.g));
    chk({e.tag, ".timeout"}, 32'(hold_timeout), 32'(e.to));
  endtask

  function automatic void add(input bit r, input logic [N-1:0] q, input bit m,
                              input logic [N-1:0] g, input bit to);
    vec_t v;
    v.rst = r; v.req = q; v.mode = m; v.eg = g; v.eto = to;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    mode  = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    req   = 4'b1111;
    mode  = 1'b0;

    // Reset holds outputs low even with every requester active.
    repeat (2) @(posedge clk);
    #1;
    e.g = '0; e.to = 1'b0; e.tag = "reset";
    cmp_out(e);
    @(negedge clk) rst_n = 1'b1;

    // RR rotation: each owner drops its req for one cycle after being granted.
    add(1, 4'b1111, 0, 4'b0001, 0);
    add(0, 4'b1110, 0, 4'b0010, 0);
    add(0, 4'b1101, 0, 4'b0100, 0);
    add(0, 4'b1011, 0, 4'b1000, 0);
    add(0, 4'b0111, 0, 4'b0001, 0);
    // Hold limit: owner 0 for four cycles, then forced to 1 with a pulse.
    add(1, 4'b0011, 0, 4'b0001, 0);
    add(0, 4'b0011, 0, 4'b0001, 0);
    add(0, 4'b0011, 0, 4'b0001, 0);
    add(0, 4'b0011, 0, 4'b0001, 0);
    add(0, 4'b0011, 0, 4'b0010, 1);
    add(0, 4'b0011, 0, 4'b0010, 0);
    // Lone requester: reaches the limit and keeps the grant, no pulse.
    add(0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, 0, 4'b0001, 0);
    add(0, 4'b0001, 0, 4'b0001, 0);
    // Fixed priority; switching mode back does not preempt the owner.
    add(1, 4'b1010, 1, 4'b0010, 0);
    add(0, 4'b1100, 1, 4'b0100, 0);
    add(0, 4'b1100, 0, 4'b0100, 0);
    // Release to idle, then IDLE->grant searching from rr_ptr+1 (3 after 2).
    add(1, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b1000, 0, 4'b1000, 0);
    // Forced rotation skips idle index 1; release then wraps the pointer to 3.
    add(1, 4'b1101, 0, 4'b0001, 0);
    add(0, 4'b1101, 0, 4'b0001, 0);
    add(0, 4'b1101, 0, 4'b0001, 0);
    add(0, 4'b1101, 0, 4'b0001, 0);
    add(0, 4'b1101, 0, 4'b0100, 1);
    add(0, 4'b1001, 0, 4'b1000, 0);

    foreach (tbl[i]) begin
      exp_t x;
      if (tbl[i].rst) do_reset();
      @(negedge clk);
      req  = tbl[i].req;
      mode = tbl[i].mode;
      x.g = tbl[i].eg; x.to = tbl[i].eto; x.tag = $sformatf("v%0d", i);
      sbq.push_back(x);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        errors++; checks++;
        $display("FAIL scoreboard: got empty queue expected entry v%0d", i);
      end else cmp_out(sbq.pop_front());
    end

    // Async reset between edges clears outputs before the next edge.
    do_reset();
    @(negedge clk) req = 4'b0010;
    @(posedge clk);
    #1;
    e.g = 4'b0010; e.to = 1'b0; e.tag = "pre_arst";
    cmp_out(e);
    #2;
    rst_n = 1'b0;
    req   = 4'b1000;
    #1;
    e.g = '0; e.tag = "arst_mid";
    cmp_out(e);
    @(negedge clk) rst_n = 1'b1;
    #1;
    e.tag = "arst_rel";
    cmp_out(e);
    @(posedge clk);
    #1;
    e.g = 4'b1000; e.tag = "post_arst";
    cmp_out(e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
